// File: rtl/mapping_table_seq.sv
// Candidate-compaction engine: scans a BS-bit mask LANES bits per cycle and
// builds a table of set-bit indices, ascending or descending, with a read port.
module mapping_table_seq #(
  parameter int BS    = 16,
  parameter int LANES = 4,
  parameter int IDXW  = $clog2(BS),
  parameter int CNTW  = $clog2(BS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:BS-1]   candidate_list,
  input  logic            descending,
  input  logic            clear,
  output logic            done,
  output logic            table_valid,
  output logic [CNTW-1:0] count,
  input  logic [IDXW-1:0] rd_addr,
  output logic [IDXW-1:0] rd_idx,
  output logic            rd_hit
);
  // state | meaning
  // IDLE  | waiting for a mask; last completed table readable while table_valid
  // SCAN  | writing up to LANES table entries per cycle from the captured mask
  // DONE  | one-cycle completion: done pulses, count and table_valid published
  localparam int NCH = BS / LANES;
  localparam int SCW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW  = $clog2(LANES);
  localparam logic [SCW-1:0] LAST_CH = SCW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [0:BS-1]   mask_q;
  logic            desc_q;
  logic            ready_q;
  logic [SCW-1:0]  chunk;
  logic [CNTW-1:0] wptr;
  logic [IDXW-1:0] tbl [BS];

  logic [IDXW-1:0]  lane_idx  [LANES];
  logic [IDXW-1:0]  lane_addr [LANES];
  logic [LANES-1:0] lane_set;
  logic [CNTW-1:0]  chunk_pop;

  // Descending order is the bitwise complement of the ascending position,
  // since BS is a power of two (BS-1-p == ~p in IDXW bits).
  always_comb begin
    logic [IDXW-1:0] base;
    logic [IDXW-1:0] pos;
    logic [CNTW-1:0] rank;
    base = IDXW'(chunk) << LW;
    pos  = '0;
    rank = '0;
    for (int j = 0; j < LANES; j++) begin
      pos          = base + IDXW'(j);
      lane_idx[j]  = desc_q ? ~pos : pos;
      lane_set[j]  = mask_q[lane_idx[j]];
      lane_addr[j] = wptr[IDXW-1:0] + rank[IDXW-1:0];
      rank         = rank + CNTW'(lane_set[j]);
    end
    chunk_pop = rank;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      desc_q      <= 1'b0;
      ready_q     <= 1'b1;
      chunk       <= '0;
      wptr        <= '0;
      count       <= '0;
      table_valid <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < BS; i++) tbl[i] <= '0;
    end else if (clear) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      count       <= '0;
      table_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid && ready_q) begin
            mask_q      <= candidate_list;
            desc_q      <= descending;
            wptr        <= '0;
            chunk       <= '0;
            table_valid <= 1'b0;
            ready_q     <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          for (int j = 0; j < LANES; j++) begin
            if (lane_set[j]) tbl[lane_addr[j]] <= lane_idx[j];
          end
          wptr  <= wptr + chunk_pop;
          chunk <= chunk + 1'b1;
          if (chunk == LAST_CH) begin
            state       <= DONE;
            done        <= 1'b1;
            count       <= wptr + chunk_pop;
            table_valid <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = ready_q && !clear;
  assign rd_hit   = table_valid && (CNTW'(rd_addr) < count);
  assign rd_idx   = rd_hit ? tbl[rd_addr] : '0;

endmodule

// File: doc/mapping_table_seq.md
Name: mapping_table_seq

Overview:
- Sequential, parametrised candidate-compaction engine.
- Accepts a BS-bit candidate mask over a valid/ready handshake. It scans LANES mask bits per cycle and builds a compacted table of the indices of set bits, in ascending or descending order.
- Exposes the population count and a random-access read port.
- Sits between the candidate generator and downstream consumers that walk selected indices.

Parameters:
- BS, 16, mask width / table depth; power of two, >= 2
- LANES, 4, mask bits examined per scan cycle; power of two, 1..BS; BS % LANES == 0
- IDXW, $clog2(BS), width of a stored index
- CNTW, $clog2(BS+1), width of the count (must represent BS, i.e. all bits set)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  candidate mask offered
- in_ready  out  1  engine can accept a mask
- candidate_list  in  [0:BS-1]  element i set => index i is a candidate
- descending  in  1  sampled with the mask; 1 = table ordered highest index first
- clear  in  1  synchronous; empties the table, aborts any scan
- done  out  1  one-cycle pulse when a table is complete
- table_valid  out  1  table and count are stable and readable
- count  out  CNTW  number of set bits in the last completed mask
- rd_addr  in  IDXW  table read address
- rd_idx  out  IDXW  combinational entry at rd_addr; 0 if rd_addr >= count or !table_valid
- rd_hit  out  1  rd_addr < count && table_valid

Behaviour:
- Reset (rst low, async):
  - state = IDLE; all table entries = 0; count = 0.
  - table_valid = 0; done = 0; in_ready = 1.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture the mask and descending, zero the internal write pointer, drop table_valid, and go to SCAN.
  - SCAN: in_ready = 0. Each cycle examines LANES bits of the captured mask.
    - Ascending: chunk k covers indices k*LANES .. k*LANES+LANES-1, in increasing index order.
    - Descending: chunks are taken from index BS-1 downward, within-chunk order also decreasing.
    - Each set bit writes its index to table[wptr + rank], where rank = the number of earlier set bits in the same chunk. Then wptr += popcount(chunk).
    - After BS/LANES scan cycles, go to DONE.
  - DONE: one cycle. done = 1, count = wptr, table_valid = 1, in_ready = 0. Then go to IDLE.
- Latency: handshake cycle t; done asserted in cycle t + BS/LANES + 1; table_valid high from that cycle until the next accepted mask or clear.
- Table entries at addresses >= count are don't-care internally. rd_idx must still return 0 for them (masked at output).
- All-zero mask: count = 0, rd_hit = 0 for every address, done still pulses.
- All-ones mask: count = BS, no overflow. Table ascending is 0..BS-1; descending is BS-1..0.
- clear:
  - In any state, next state = IDLE with count = 0, table_valid = 0, done = 0.
  - clear has priority over a simultaneous in_valid; that handshake does not occur (in_ready forced 0 while clear = 1).
- Changes on candidate_list or descending after the handshake cycle have no effect on the scan in progress.
- rst asserted mid-SCAN: immediate return to reset values; a partial table is never marked valid.
- No back-pressure on done; consumers must sample it in its cycle.

Test Plan:
- BS=16, LANES=4: reset, mask with indices 1,4,5,15 set, ascending -> done at cycle t+5, count=4, rd 0..3 = 1,4,5,15; rd_addr=4 -> rd_idx=0, rd_hit=0.
- Same mask, descending=1 -> rd 0..3 = 15,5,4,1; count=4.
- All-ones mask -> count=16 (CNTW=5); rd_addr=15 gives 15 ascending and 0 descending. All-zero mask -> count=0, done pulses, rd_hit=0 everywhere.
- Mask offered during SCAN -> in_ready=0, not accepted. Mask changed on input mid-scan -> table reflects the originally captured mask.
- clear asserted in the 2nd SCAN cycle together with in_valid -> IDLE next cycle, count=0, table_valid=0, no done. A new mask next cycle is then accepted normally.
- rst pulsed low mid-SCAN (asynchronously, between edges) -> outputs at reset values immediately. Repeat the first scenario with LANES=1 and LANES=16 -> latencies 17 and 2 cycles, identical tables.
